// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add unsigned multiplier, N-bit operands, 16-bit product.
// Latency: start sampled at edge k -> done pulse and valid prod in the cycle after edge k+N.
// Backpressure: none; start is ignored while busy, and start in DONE chains a new operation.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst_n  - synchronous active-low reset
//   start  - begin a multiply (accepted in IDLE or DONE)
//   a, b   - unsigned multiplicand / multiplier, captured on the accepting edge
//   prod   - a*b zero-extended to 16 bits, held from one DONE to the next
//   busy   - high while in CALC
//   done   - one-cycle completion pulse (state DONE)
module seq_multiplier #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [15:0]  prod,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]     state_q,  state_d;
  logic [2*N-1:0] mcand_q,  mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] acc_q,    acc_d;
  logic [CW-1:0]  cnt_q,    cnt_d;
  logic [15:0]    prod_q,   prod_d;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;

    case (state_q)
      ST_CALC: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Last iteration: publish the updated accumulator in the same edge,
        // so done lands exactly N edges after the capture edge.
        if (cnt_q == CW'(N - 1)) begin
          prod_d  = 16'(acc_d);
          state_d = ST_DONE;
        end
      end
      default: begin
        // IDLE and DONE behave identically: start chains, otherwise rest in IDLE.
        if (start) begin
          mcand_d  = {{N{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_CALC;
        end else begin
          state_d  = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
    end
  end

  assign prod = prod_q;
  assign busy = (state_q == ST_CALC);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

  localparam int N = 6;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [15:0]  prod;
  logic         busy;
  logic         done;

  int checks;
  int errors;
  int last_prod;

  seq_multiplier #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .prod  (prod),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation from the current (IDLE or DONE) cycle. Operands are
  // scrambled every cycle after capture; optionally start is re-pulsed in
  // CALC cycle pulse_at (negative = never). Ends in the done cycle.
  task automatic run_op(input int ta, input int tb_, input bit full, input int pulse_at);
    int exp;
    exp   = ta * tb_;
    start = 1'b1;
    a     = N'(ta);
    b     = N'(tb_);
    step();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      a = N'($urandom);
      b = N'($urandom);
      start = (i == pulse_at);
      if (full) begin
        check("busy_calc", busy, 1);
        check("done_calc", done, 0);
        check("prod_hold_calc", prod, last_prod);
      end
      step();
    end
    start = 1'b0;
    check("done_pulse", done, 1);
    check("prod", prod, exp);
    if (full) begin
      check("busy_done", busy, 0);
      check("prod_hi_zero", prod[15:2*N], 0);
    end
    if (tb_ != 0) begin
      check("inv_quot", prod / tb_, ta);
      check("inv_rem", prod % tb_, 0);
    end
    last_prod = exp;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("idle_prod", prod, last_prod);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_prod = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;

    repeat (3) step();
    check("rst_prod", prod, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // Start accepted on the very first edge with reset released.
    rst_n = 1'b1;
    run_op(13, 11, 1'b1, -1);
    idle_cycles(2);

    run_op(63, 63, 1'b1, -1);
    idle_cycles(1);
    run_op(0, 45, 1'b1, -1);
    idle_cycles(1);

    // Start pulsed during CALC must be ignored.
    run_op(5, 7, 1'b1, 2);
    idle_cycles(3);

    // Back-to-back: new start issued in the DONE cycle.
    run_op(9, 9, 1'b1, -1);
    run_op(3, 4, 1'b1, -1);
    idle_cycles(1);

    // Reset in the middle of CALC aborts without a done pulse.
    start = 1'b1;
    a     = N'(17);
    b     = N'(29);
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    last_prod = 0;
    check("abort_prod", prod, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    rst_n = 1'b1;
    idle_cycles(N + 2);
    run_op(2, 3, 1'b1, -1);
    idle_cycles(1);

    // Random operations with full per-cycle checks.
    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 1'b1,
             int'($urandom_range(0, N + 3)) - 2);
      if ($urandom_range(0, 1) == 1) idle_cycles(1);
    end

    // Exhaustive sweep, chained back-to-back.
    for (int ia = 0; ia < 64; ia++) begin
      for (int ib = 0; ib < 64; ib++) begin
        run_op(ia, ib, 1'b0, -1);
      end
    end
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have a parameter N, default 6, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply.
REQ-005 The block SHALL have port a, input, N bits: unsigned multiplicand.
REQ-006 The block SHALL have port b, input, N bits: unsigned multiplier.
REQ-007 The block SHALL have port prod, output reg, 16 bits: the unsigned product a*b, zero-extended above bit 2N-1.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.

Function
REQ-010 The block SHALL implement a radix-2 shift-add multiplier with three states: IDLE, CALC, DONE.
REQ-011 In IDLE or DONE, if start=1 at a rising edge, the block SHALL capture a and b into internal registers, clear the accumulator and iteration counter, and enter CALC.
REQ-012 In IDLE or DONE with start=0, the block SHALL go to or stay in IDLE.
REQ-013 In CALC, on each edge, the block SHALL add the shifted multiplicand to the accumulator when the current multiplier LSB is 1, shift the multiplicand left by one and the multiplier right by one, and increment the counter.
REQ-014 After exactly N CALC edges the block SHALL write the accumulator (2N bits, no truncation) into prod[2N-1:0], clear prod[15:2N], and enter DONE.
REQ-015 Latency: start sampled at edge k SHALL yield done=1 and a valid prod during the cycle following edge k+N (k+6 for N=6), regardless of operand values, including zero.
REQ-016 busy SHALL be 1 exactly while the state is CALC and 0 in IDLE and DONE.
REQ-017 done SHALL be 1 exactly while the state is DONE, which SHALL last one cycle.
REQ-018 start asserted during CALC SHALL be ignored; the operation in flight SHALL continue with its captured operands.
REQ-019 Changes on a or b after capture SHALL NOT affect the result.
REQ-020 prod SHALL hold its last value from DONE until the next DONE, and SHALL NOT change during CALC.
REQ-021 start=1 while in DONE SHALL begin a new operation back-to-back, so done rises at most once every N+1 cycles.
REQ-022 The design SHALL support N from 2 to 8, since 2N must be 16 or less.

Reset
REQ-023 When rst_n=0 at a rising edge, the block SHALL enter IDLE with prod=0, busy=0, done=0, and the accumulator, counter and operand registers cleared.
REQ-024 Reset SHALL take priority over start and over an operation in progress; the aborted operation SHALL NOT produce a done pulse.
REQ-025 In the first edge with rst_n=1, a start=1 SHALL be accepted normally.

Verification
REQ-026 Basic: reset, then a=6'd13, b=6'd11, start one cycle -> busy high for 6 cycles, then done=1 for one cycle with prod=16'd143; prod still 143 two cycles later.
REQ-027 Extremes: a=63, b=63 -> prod=16'd3969 with prod[15:12]=0; a=0, b=45 -> prod=0 with done still at the 7th cycle.
REQ-028 Busy-ignore and stability: start a=5, b=7; at cycle 3 pulse start with a=2, b=2 and change a/b every cycle -> single done, prod=35, no second operation.
REQ-029 Back-to-back: hold start=1 with a=9, b=9, then a=3, b=4 loaded in DONE -> done pulses 7 cycles apart, prod=81 then prod=12.
REQ-030 Reset mid-operation: rst_n=0 at cycle 3 of CALC -> prod=0, busy=0, done never asserted; next start a=2, b=3 -> prod=6.
REQ-031 Exhaustive inverse check: for all 4096 (a,b) pairs, prod equals a*b, and for b not zero, prod divided by b gives a with remainder 0.
